inst_fetch_queue: RTL and testbench

Responder side of the fetch-address interface driven by the PC generator. Accepts `pc_i`/`inst_en_i` each cycle, issues in-order requests on the SRAM-like instruction bus, and holds returned words in a small in-order queue. It presents them to decode with their PC and fetch-exception tag. It back-pressures the PC through a stall request and discards in-flight responses after a flush.

---
 rtl/inst_fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Sits between the PC generator and decode. Each valid fetch address is
//   sent as a request on the SRAM-like instruction bus. Exception fetches
//   never use the bus. The returned words are held in a small in-order
//   circular queue. The head entry is presented to decode together with its
//   PC and exception tag.
//   After a flush, the responses still owed by the bus for killed requests
//   are counted in `discard` and silently dropped. New normal fetches wait
//   until that count reaches zero.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   pc_i, inst_en_i     fetch address and its valid flag
//   is_exception_i      fetch carries an exception (misaligned PC)
//   exception_cause_i   cause code for an exception fetch
//   flush_i             kills every queued and in-flight fetch
//   pause_i             decode stall; the head entry is held
//   stall_req_o         PC generator must hold pc_i
//   inst_req_o          bus request
//   inst_addr_o         bus address
//   inst_addr_ok_i      bus accepted the request this cycle
//   inst_data_ok_i      bus returns one in-order response word this cycle
//   inst_rdata_i        bus response word
//   inst_valid_o        head entry valid for decode
//   inst_o              head instruction (0 for exception entries)
//   inst_pc_o           head PC
//   is_exception_o      head exception tag
//   exception_cause_o   head exception cause
module inst_fetch_queue #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        inst_en_i,
  input  logic        is_exception_i,
  input  logic [6:0]  exception_cause_i,
  input  logic        flush_i,
  input  logic        pause_i,
  output logic        stall_req_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        is_exception_o,
  output logic [6:0]  exception_cause_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]           slot_pc    [FIFO_DEPTH];
  logic [31:0]           slot_rdata [FIFO_DEPTH];
  logic                  slot_exc   [FIFO_DEPTH];
  logic [6:0]            slot_cause [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_done;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] owed;
  logic [CNT_W-1:0] discard_flush;

  logic             space;
  logic             push_exc;
  logic             push_bus;
  logic             push;
  logic             pop;
  logic             head_vis;
  logic             resp_hit;
  logic             found;
  logic [PTR_W-1:0] resp_idx;

  // Space uses the current occupancy, so a same-cycle pop never makes room
  // for a push.
  assign space       = (cnt < DEPTH_C);
  assign inst_req_o  = inst_en_i & ~is_exception_i & ~flush_i & space & (discard == '0);
  assign inst_addr_o = pc_i;
  assign push_exc    = inst_en_i & is_exception_i & ~flush_i & space;
  assign push_bus    = inst_req_o & inst_addr_ok_i;
  assign push        = push_exc | push_bus;
  assign stall_req_o = inst_en_i & ~flush_i & ~push;

  // Responses return in order. Exception slots are already done, so the
  // target is the oldest allocated slot whose done bit is still clear.
  always_comb begin
    found    = 1'b0;
    resp_idx = head;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (!found && (CNT_W'(i) < cnt) && !slot_done[head + PTR_W'(i)]) begin
        found    = 1'b1;
        resp_idx = head + PTR_W'(i);
      end
    end
  end

  // A word with nothing owed and nothing pending is a protocol error.
  // It is simply ignored.
  assign resp_hit = inst_data_ok_i & ~flush_i & (discard == '0) & (pend != '0) & found;

  // Everything still owed by the bus becomes discard. A word arriving in the
  // flush cycle itself is one of those, so it is taken off straight away.
  assign owed          = discard + pend;
  assign discard_flush = (inst_data_ok_i && (owed != '0)) ? owed - CNT_W'(1) : owed;

  assign head_vis          = (cnt != '0);
  assign inst_valid_o      = head_vis & slot_done[head] & ~flush_i;
  assign pop               = inst_valid_o & ~pause_i;
  assign inst_o            = head_vis ? slot_rdata[head] : '0;
  assign inst_pc_o         = head_vis ? slot_pc[head]    : '0;
  assign is_exception_o    = head_vis ? slot_exc[head]   : 1'b0;
  assign exception_cause_o = head_vis ? slot_cause[head] : '0;

  // Control state: pointers, counters and done bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      pend      <= '0;
      discard   <= '0;
      slot_done <= '0;
    end else if (flush_i) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      pend    <= '0;
      discard <= discard_flush;
    end else begin
      if (push) begin
        tail            <= tail + PTR_W'(1);
        slot_done[tail] <= push_exc;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (resp_hit) begin
        slot_done[resp_idx] <= 1'b1;
      end
      if (inst_data_ok_i && (discard != '0)) begin
        discard <= discard - CNT_W'(1);
      end
      cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
      pend <= pend + CNT_W'(push_bus) - CNT_W'(resp_hit);
    end
  end

  // Slot payload. It is only observed through cnt/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_pc[tail]    <= pc_i;
      slot_exc[tail]   <= push_exc;
      slot_cause[tail] <= push_exc ? exception_cause_i : 7'd0;
      if (push_exc) begin
        slot_rdata[tail] <= '0;
      end
    end
    if (resp_hit) begin
      slot_rdata[resp_idx] <= inst_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;
  localparam logic [6:0]  ADEF  = 7'h08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        inst_en_i = 1'b0;
  logic        is_exception_i = 1'b0;
  logic [6:0]  exception_cause_i = '0;
  logic        flush_i = 1'b0;
  logic        pause_i = 1'b0;
  logic        stall_req_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        is_exception_o;
  logic [6:0]  exception_cause_o;

  always #5 clk = ~clk;

  inst_fetch_queue #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .inst_en_i         (inst_en_i),
    .is_exception_i    (is_exception_i),
    .exception_cause_i (exception_cause_i),
    .flush_i           (flush_i),
    .pause_i           (pause_i),
    .stall_req_o       (stall_req_o),
    .inst_req_o        (inst_req_o),
    .inst_addr_o       (inst_addr_o),
    .inst_addr_ok_i    (inst_addr_ok_i),
    .inst_data_ok_i    (inst_data_ok_i),
    .inst_rdata_i      (inst_rdata_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o),
    .is_exception_o    (is_exception_o),
    .exception_cause_o (exception_cause_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [6:0]  cause;
    logic        done;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } bus_t;

  ent_t mq[$];     // reference queue contents
  ent_t sb[$];     // expected decode stream, popped by the monitor
  bus_t bus_q[$];  // requests accepted by the bus, not yet answered
  int   discard_m = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;

  bit k_en, k_exc, k_flush, k_pause, k_aok, k_resp;
  logic [31:0] pc_gen = '0;
  logic        s_req, s_stall;
  logic [31:0] s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int m_pend();
    int p = 0;
    foreach (mq[i]) if (!mq[i].done) p++;
    return p;
  endfunction

  function automatic bit m_req();
    return inst_en_i && !is_exception_i && !flush_i && (mq.size() < DEPTH) && (discard_m == 0);
  endfunction

  function automatic bit m_push();
    return inst_en_i && !flush_i && (mq.size() < DEPTH) &&
           (is_exception_i || (m_req() && inst_addr_ok_i));
  endfunction

  task automatic check_comb();
    chk("req", inst_req_o, m_req());
    chk("stall", stall_req_o, inst_en_i && !flush_i && !m_push());
    chk("valid", inst_valid_o, (mq.size() != 0) && mq[0].done && !flush_i);
    if (inst_req_o) chk("addr", inst_addr_o, pc_i);
    s_req   = inst_req_o;
    s_stall = stall_req_o;
    s_addr  = inst_addr_o;
  endtask

  task automatic model_update();
    bit   push, pop;
    int   pend;
    ent_t e;
    pend = m_pend();
    push = m_push();
    pop  = (mq.size() != 0) && mq[0].done && !flush_i && !pause_i;
    if (flush_i) begin
      discard_m = discard_m + pend - ((inst_data_ok_i && (discard_m + pend) > 0) ? 1 : 0);
      mq.delete();
      sb.delete();
    end else begin
      if (inst_data_ok_i) begin
        if (discard_m > 0) discard_m--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].done) begin
              mq[i].done = 1'b1;
              break;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = pc_i;
        e.exc   = is_exception_i;
        e.cause = is_exception_i ? exception_cause_i : 7'd0;
        e.inst  = is_exception_i ? 32'd0 : (pc_i ^ KEY);
        e.done  = is_exception_i;
        mq.push_back(e);
        sb.push_back(e);
      end
    end
  endtask

  task automatic cycle();
    bus_t b;
    @(negedge clk);
    inst_en_i         = k_en;
    is_exception_i    = k_exc;
    exception_cause_i = k_exc ? ADEF : 7'd0;
    pc_i              = k_exc ? (pc_gen | 32'd2) : pc_gen;
    flush_i           = k_flush;
    pause_i           = k_pause;
    inst_addr_ok_i    = k_aok;
    if (k_resp && bus_q.size() != 0 && bus_q[0].cyc < cyc) begin
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = bus_q[0].addr ^ KEY;
    end else begin
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = $urandom;
    end
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    if (inst_data_ok_i) void'(bus_q.pop_front());
    if (s_req && inst_addr_ok_i) begin
      b.addr = s_addr;
      b.cyc  = cyc;
      bus_q.push_back(b);
    end
    if (inst_en_i && !s_stall) pc_gen += 32'd4;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_en_i = 1'b0; is_exception_i = 1'b0; exception_cause_i = '0;
    flush_i = 1'b0; pause_i = 1'b0; inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    @(posedge clk);
    mq.delete(); sb.delete(); bus_q.delete(); discard_m = 0;
    @(negedge clk);
    #1;
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_req", inst_req_o, 0);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    chk("rst_exc", is_exception_o, 0);
    chk("rst_cause", exception_cause_o, 0);
    rst = 1'b0;
  endtask

  task automatic set_knobs(input bit en, input bit exc, input bit fl, input bit pa,
                           input bit aok, input bit resp);
    k_en = en; k_exc = exc; k_flush = fl; k_pause = pa; k_aok = aok; k_resp = resp;
  endtask

  task automatic drain(input int n);
    set_knobs(0, 0, 0, 0, 1, 1);
    repeat (n) cycle();
  endtask

  task automatic stream(input string name, input int n);
    int p0;
    pc_gen = 32'h1C000000;
    set_knobs(1, 0, 0, 0, 1, 1);
    p0 = pops;
    repeat (n) cycle();
    chk(name, pops - p0, n - 2);
  endtask

  // Scoreboard monitor: consumes one expected entry per decode handshake.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid_o && !pause_i) begin
        pops++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected at cycle %0d: got pc %h, expected no entry", cyc, inst_pc_o);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", inst_pc_o, e.pc);
          chk("pop_inst", inst_o, e.inst);
          chk("pop_exc", is_exception_o, e.exc);
          chk("pop_cause", exception_cause_o, e.cause);
        end
      end
    end
  end

  initial begin : driver
    int p0;
    do_reset();

    // Streaming: one fetch per cycle, response one cycle later.
    stream("stream_pops", 20);
    drain(6);

    // Full queue under pause, then release.
    pc_gen = 32'h1C000000;
    set_knobs(1, 0, 0, 1, 1, 1);
    repeat (6) cycle();
    chk("full_stall", s_stall, 1);
    chk("full_req", s_req, 0);
    k_pause = 0;
    repeat (4) cycle();
    drain(8);

    // Flush with three requests in flight.
    pc_gen = 32'h1C000000;
    set_knobs(1, 0, 0, 0, 1, 0);
    repeat (3) cycle();
    set_knobs(0, 0, 1, 0, 1, 0);
    cycle();
    pc_gen = 32'h1C000100;
    set_knobs(1, 0, 0, 0, 1, 1);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("flush_req", s_req, (i == 3) ? 1 : 0);
    end
    k_en = 0;
    repeat (6) cycle();
    chk("flush_pops", pops - p0, 1);

    // Flush in the same cycle as a response, with two pending.
    pc_gen = 32'h1C000300;
    set_knobs(1, 0, 0, 0, 1, 0);
    repeat (2) cycle();
    set_knobs(0, 0, 1, 0, 1, 1);
    cycle();
    pc_gen = 32'h1C000400;
    set_knobs(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("coinc_req", s_req, (i == 1) ? 1 : 0);
    end
    k_en = 0;
    repeat (5) cycle();

    // Misaligned PC behind one pending normal fetch.
    drain(4);
    pc_gen = 32'h1C000200;
    set_knobs(1, 0, 0, 0, 1, 0);
    cycle();
    k_exc = 1;
    cycle();
    chk("misalign_req", s_req, 0);
    p0 = pops;
    set_knobs(0, 0, 0, 0, 1, 1);
    repeat (5) cycle();
    chk("misalign_pops", pops - p0, 2);

    // Randomized traffic.
    pc_gen = 32'h1C000000;
    for (int i = 0; i < 3000; i++) begin
      k_en    = ($urandom % 4) != 0;
      k_exc   = ($urandom % 10) == 0;
      k_flush = ($urandom % 25) == 0;
      k_pause = ($urandom % 3) == 0;
      k_aok   = ($urandom % 4) != 0;
      k_resp  = ($urandom % 3) != 0;
      if (k_flush) pc_gen = {$urandom_range(32'h0FFFFFFF, 0), 4'h0};
      cycle();
    end
    drain(20);
    chk("drain_empty", sb.size(), 0);

    // Reset with entries queued, then streaming again.
    pc_gen = 32'h1C000000;
    set_knobs(1, 0, 0, 1, 1, 1);
    repeat (3) cycle();
    do_reset();
    stream("restream_pops", 12);
    drain(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
